// File: rtl/data_io_wide.sv
// SPI file-download receiver: assembles io-controller bytes into BYTES-wide words and writes them via a FIFO + req/ack port.
// Optional DATA_IO_CHECKSUM_EN adds a 16-bit byte checksum output.
module data_io_wide #(
  parameter int              BYTES      = 2,
  parameter int              AW         = 25,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [AW-1:0]   BOOT_BASE  = 25'h80000,
  parameter logic [AW-1:0]   FILE_BASE  = 25'hA0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_sck,
  input  logic                 spi_ss,
  input  logic                 spi_sdi,
  output logic                 downloading,
  output logic [4:0]           index,
  output logic [AW-1:0]        size,
  output logic                 overflow,
  output logic [AW-1:0]        ram_addr,
  output logic [8*BYTES-1:0]   ram_din,
  output logic [BYTES-1:0]     ram_be,
  output logic                 ram_wr_req,
  input  logic                 ram_wr_ack
`ifdef DATA_IO_CHECKSUM_EN
  , output logic [15:0]        checksum
`endif
);

  // dl state  | meaning
  // DL_IDLE   | no transfer, FIFO drained
  // DL_ACTIVE | start received, collecting data bytes
  // DL_ENDING | end received, waiting for FIFO and write port to drain
  // wr state  | meaning
  // WR_IDLE   | no request; loads FIFO head when available
  // WR_WAIT   | ram_wr_req held until ram_wr_ack

  localparam int DW = 8*BYTES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = AW + DW + BYTES;
  localparam logic [1:0] LMASK = 2'(BYTES-1);

  typedef enum logic [1:0] {DL_IDLE, DL_ACTIVE, DL_ENDING} dl_state_t;
  typedef enum logic {WR_IDLE, WR_WAIT} wr_state_t;

  logic [2:0]       sck_sync_q, sck_sync_d;
  logic [1:0]       ss_sync_q, ss_sync_d, sdi_sync_q, sdi_sync_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [6:0]       sr_q, sr_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [AW-1:0]    offset_q, offset_d, base_q, base_d, size_q, size_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    word_q, word_d, din_q, din_d, word_new;
  logic [BYTES-1:0] be_q, be_d, fl_be;
  logic [4:0]       index_q, index_d;
  logic             ovf_q, ovf_d, req_q, req_d;
  dl_state_t        dl_q, dl_d;
  wr_state_t        wr_q, wr_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
`ifdef DATA_IO_CHECKSUM_EN
  logic [15:0]      cs_q, cs_d;
  logic             cs_pend_q, cs_pend_d;
  logic [7:0]       cs_byte_q, cs_byte_d;
`endif

  logic          sck_rise, byte_done, start_evt, push, push_ok, pop, full;
  logic [7:0]    rx_byte;
  logic [1:0]    lane;
  logic [AW-1:0] word_addr;
  logic [EW-1:0] push_entry;

  assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign rx_byte   = {sr_q, sdi_sync_q[1]};
  assign byte_done = ~ss_sync_q[1] & sck_rise & (cnt_q == 4'd15);
  assign start_evt = byte_done & (cmd_q == 8'h53) & rx_byte[0];
  assign lane      = offset_q[1:0] & LMASK;
  assign word_addr = base_q + offset_q - AW'(lane);
  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));

  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], spi_sck};
    ss_sync_d  = {ss_sync_q[0], spi_ss};
    sdi_sync_d = {sdi_sync_q[0], spi_sdi};
    cnt_d = cnt_q;      sr_d = sr_q;        cmd_d = cmd_q;
    offset_d = offset_q; base_d = base_q;   size_d = size_q;
    word_d = word_q;    index_d = index_q;  ovf_d = ovf_q;
    dl_d = dl_q;        wr_d = wr_q;        req_d = req_q;
    addr_d = addr_q;    din_d = din_q;      be_d = be_q;
    mem_d = mem_q;      wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    push = 1'b0; push_ok = 1'b0; pop = 1'b0; push_entry = '0;
    word_new = word_q;
    for (int i = 0; i < BYTES; i++) begin
      if (lane == 2'(i)) word_new[8*i +: 8] = rx_byte;
      fl_be[i] = (2'(i) < lane);
    end

    if (ss_sync_q[1]) begin
      cnt_d = 4'd0;
      sr_d  = '0;
    end else if (sck_rise) begin
      sr_d = rx_byte[6:0];
      if (cnt_q == 4'd7) begin
        cmd_d = rx_byte;
        cnt_d = 4'd8;
      end else if (cnt_q == 4'd15) begin
        cnt_d = 4'd8;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    // ENDING completes first so a start arriving in the same cycle still wins
    if (dl_q == DL_ENDING && count_q == '0 && !req_q) dl_d = DL_IDLE;

    if (byte_done) begin
      case (cmd_q)
        8'h53: begin
          word_d = '0;
          if (start_evt) begin
            offset_d = '0;
            ovf_d    = 1'b0;
            base_d   = (index_q == 5'd0) ? BOOT_BASE : FILE_BASE;
            dl_d     = DL_ACTIVE;
          end else begin
            if (lane != 2'd0) begin
              push       = 1'b1;
              push_entry = {word_addr, word_q, fl_be};
            end
            size_d = offset_q;
            dl_d   = DL_ENDING;
          end
        end
        8'h54: begin
          word_d   = word_new;
          offset_d = offset_q + AW'(1);
          if (lane == LMASK) begin
            push       = 1'b1;
            push_entry = {word_addr, word_new, {BYTES{1'b1}}};
            word_d     = '0;
          end
        end
        8'h55: if (dl_q == DL_IDLE) index_d = rx_byte[4:0];
        default: ;
      endcase
    end

    case (wr_q)
      WR_IDLE: if (count_q != '0) begin
        {addr_d, din_d, be_d} = mem_q[rd_ptr_q];
        req_d = 1'b1;
        wr_d  = WR_WAIT;
      end
      WR_WAIT: if (ram_wr_ack) begin
        pop   = 1'b1;
        req_d = 1'b0;
        wr_d  = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase

    // a full FIFO still accepts a push when its head pops in the same cycle
    if (push && (!full || pop)) begin
      push_ok          = 1'b1;
      mem_d[wr_ptr_q]  = push_entry;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end else if (push) begin
      ovf_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);

`ifdef DATA_IO_CHECKSUM_EN
    cs_pend_d = byte_done & (cmd_q == 8'h54);
    cs_byte_d = rx_byte;
    cs_d      = cs_q;
    if (start_evt)      cs_d = '0;
    else if (cs_pend_q) cs_d = cs_q + {8'h00, cs_byte_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= '0; ss_sync_q <= '0; sdi_sync_q <= '0;
      cnt_q <= '0; sr_q <= '0; cmd_q <= '0;
      offset_q <= '0; base_q <= '0; size_q <= '0; word_q <= '0;
      index_q <= '0; ovf_q <= 1'b0; dl_q <= DL_IDLE; wr_q <= WR_IDLE;
      req_q <= 1'b0; addr_q <= '0; din_q <= '0; be_q <= '0;
      mem_q <= '{default: '0};
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
`ifdef DATA_IO_CHECKSUM_EN
      cs_q <= '0; cs_pend_q <= 1'b0; cs_byte_q <= '0;
`endif
    end else begin
      sck_sync_q <= sck_sync_d; ss_sync_q <= ss_sync_d; sdi_sync_q <= sdi_sync_d;
      cnt_q <= cnt_d; sr_q <= sr_d; cmd_q <= cmd_d;
      offset_q <= offset_d; base_q <= base_d; size_q <= size_d; word_q <= word_d;
      index_q <= index_d; ovf_q <= ovf_d; dl_q <= dl_d; wr_q <= wr_d;
      req_q <= req_d; addr_q <= addr_d; din_q <= din_d; be_q <= be_d;
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
`ifdef DATA_IO_CHECKSUM_EN
      cs_q <= cs_d; cs_pend_q <= cs_pend_d; cs_byte_q <= cs_byte_d;
`endif
    end
  end

  assign downloading = (dl_q != DL_IDLE);
  assign index       = index_q;
  assign size        = size_q;
  assign overflow    = ovf_q;
  assign ram_addr    = addr_q;
  assign ram_din     = din_q;
  assign ram_be      = be_q;
  assign ram_wr_req  = req_q;
`ifdef DATA_IO_CHECKSUM_EN
  assign checksum    = cs_q;
`endif

endmodule

// File: tb/tb_data_io_wide.sv
// Scoreboard bench for data_io_wide (BYTES=2, FIFO_DEPTH=4); checksum checked when DATA_IO_CHECKSUM_EN is defined.
module tb_data_io_wide;
  localparam int DEPTH = 4;
  localparam logic [24:0] BOOT = 25'h80000;
  localparam logic [24:0] FILE = 25'hA0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        spi_sck = 1'b0, spi_ss = 1'b1, spi_sdi = 1'b0;
  logic        downloading, overflow, ram_wr_req, ram_wr_ack = 1'b0;
  logic [4:0]  index;
  logic [24:0] size, ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_be;
`ifdef DATA_IO_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  data_io_wide #(.BYTES(2), .AW(25), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_sdi(spi_sdi),
    .downloading(downloading), .index(index), .size(size), .overflow(overflow),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_be(ram_be),
    .ram_wr_req(ram_wr_req), .ram_wr_ack(ram_wr_ack)
`ifdef DATA_IO_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [42:0] exp_q[$];
  logic        ack_en = 1'b1;

  // model state
  logic [24:0] m_off, m_base, m_size;
  logic [15:0] m_word, m_cs;
  logic [4:0]  m_index = '0;
  logic        m_ovf = 1'b0, m_dl = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    spi_sdi = b;
    repeat (3) @(negedge clk);
    spi_sck = 1'b1;
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic spi_sel();
    spi_ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_desel();
    repeat (3) @(negedge clk);
    spi_ss = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_cmd1(input logic [7:0] c, input logic [7:0] p);
    spi_sel(); spi_byte(c); spi_byte(p); spi_desel();
  endtask

  task automatic m_push(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
    if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back({a, d, be});
  endtask

  task automatic do_index(input logic [7:0] v);
    if (!m_dl) m_index = v[4:0];
    spi_cmd1(8'h55, v);
  endtask

  task automatic do_start();
    m_off = '0; m_word = '0; m_ovf = 1'b0; m_cs = '0; m_dl = 1'b1;
    m_base = (m_index == 5'd0) ? BOOT : FILE;
    spi_cmd1(8'h53, 8'h01);
  endtask

  task automatic do_data(input logic [7:0] b[$]);
    spi_sel();
    spi_byte(8'h54);
    foreach (b[i]) begin
      m_word[8*m_off[0] +: 8] = b[i];
      m_cs = m_cs + {8'h00, b[i]};
      if (m_off[0]) begin
        m_push(m_base + m_off - 25'd1, m_word, 2'b11);
        m_word = '0;
      end
      m_off = m_off + 25'd1;
      spi_byte(b[i]);
    end
    spi_desel();
  endtask

  task automatic do_end();
    if (m_off[0]) m_push(m_base + m_off - 25'd1, m_word, 2'b01);
    m_size = m_off;
    spi_cmd1(8'h53, 8'h00);
  endtask

  task automatic wait_dl_fall();
    for (int i = 0; i < 3000 && downloading; i++) @(negedge clk);
    check_val("dl_fall", downloading, 1'b0);
    m_dl = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_val("rst_downloading", downloading, 1'b0);
    check_val("rst_index", index, 5'd0);
    check_val("rst_size", size, 25'd0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_req", ram_wr_req, 1'b0);
    check_val("rst_addr", ram_addr, 25'd0);
    check_val("rst_din", ram_din, 16'd0);
    check_val("rst_be", ram_be, 2'd0);
  endtask

  // memory side: compare each new request against the scoreboard, then ack after a short random delay
  initial begin
    logic [42:0] e;
    forever begin
      @(negedge clk);
      if (ram_wr_req && ack_en && !ram_wr_ack && !reset) begin
        if (exp_q.size() == 0) begin
          check_val("wr_unexpected", ram_wr_req, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_val("wr_addr", ram_addr, e[42:18]);
          check_val("wr_din", ram_din, e[17:2]);
          check_val("wr_be", ram_be, e[1:0]);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ram_wr_ack = 1'b1;
        @(negedge clk);
        ram_wr_ack = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // file index 1, four bytes, even length
    do_index(8'h01);
    check_val("index_set", index, m_index);
    do_start();
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_data(q);
    do_end();
    wait_dl_fall();
    check_val("size_4", size, m_size);

    // index truncated to 5 bits, ignored while downloading, odd length flush
    do_index(8'h20);
    check_val("index_trunc", index, m_index);
    do_start();
    do_index(8'h07);
    check_val("index_ignored", index, m_index);
    q = '{8'h01, 8'h02, 8'h03};
    do_data(q);
    do_end();
    wait_dl_fall();
    check_val("size_3", size, m_size);

    // mid-byte deselect discards the partial byte
    do_start();
    q = '{8'hAA};
    do_data(q);
    spi_sel(); spi_byte(8'h54); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_desel();
    q = '{8'hBB};
    do_data(q);
    do_end();
    wait_dl_fall();
    check_val("size_desel", size, m_size);

    // overflow with memory stalled
    ack_en = 1'b0;
    do_start();
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h30 + i));
    do_data(q);
    check_val("overflow_set", overflow, m_ovf);
    check_val("overflow_model", m_ovf, 1'b1);
    do_end();
    ack_en = 1'b1;
    wait_dl_fall();
    check_val("size_ovf", size, m_size);
    do_start();
    check_val("overflow_clr", overflow, 1'b0);
    do_end();
    wait_dl_fall();
    check_val("size_0", size, m_size);

`ifdef DATA_IO_CHECKSUM_EN
    do_start();
    q = '{8'hFF, 8'hFF, 8'h02};
    do_data(q);
    do_end();
    wait_dl_fall();
    check_val("checksum", checksum, m_cs);
    check_val("checksum_val", m_cs, 16'h0200);
`endif

    // reset while a request is outstanding
    ack_en = 1'b0;
    do_start();
    q = '{8'h11, 8'h22};
    do_data(q);
    for (int i = 0; i < 200 && !ram_wr_req; i++) @(negedge clk);
    check_val("pre_rst_req", ram_wr_req, 1'b1);
    check_val("pre_rst_dl", downloading, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    exp_q.delete();
    m_index = '0; m_dl = 1'b0;
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    check_val("post_rst_req", ram_wr_req, 1'b0);

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_io_wide.md
Name: data_io_wide

Overview:
- Parametrised successor of the MiST SPI file-download block.
- Receives the io-controller SPI stream (file-index, file-transfer and file-data commands) and assembles bytes into words of configurable width with byte enables.
- Buffers assembled words in a small FIFO and writes them to external RAM through a request/acknowledge handshake, so slow or arbitrated memories no longer lose data.
- Sits between the io-controller SPI pins and the system memory arbiter.

Parameters:
BYTES, 2, bytes per RAM word (1, 2 or 4); ram_din width is 8*BYTES.
AW, 25, RAM byte-address width.
FIFO_DEPTH, 4, write-buffer entries (power of two, 2..16).
BOOT_BASE, 25'h80000, load base when index==0.
FILE_BASE, 25'hA0000, load base when index!=0.

Ports:
clk  in  1  system clock; also oversamples SPI.
reset  in  1  synchronous, active-high.
spi_sck  in  1  SPI clock, asynchronous to clk.
spi_ss  in  1  SPI select, active-high deselect.
spi_sdi  in  1  SPI data, MSB first.
downloading  out  1  transfer active or FIFO not yet drained.
index  out  5  menu index of the current file.
size  out  AW  bytes received in the last completed transfer.
overflow  out  1  sticky: a byte was dropped because the FIFO was full.
ram_addr  out  AW  byte address, aligned to BYTES.
ram_din  out  8*BYTES  write data, little-endian byte lanes.
ram_be  out  BYTES  byte enables.
ram_wr_req  out  1  write request.
ram_wr_ack  in  1  one-cycle acknowledge from memory.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: downloading=0, index=0, size=0, overflow=0, ram_wr_req=0, ram_addr=0, ram_din=0, ram_be=0. FIFO empty, bit counter 0.
- SPI sampling:
  - spi_sck, spi_ss and spi_sdi pass through 2-FF synchronisers.
  - An sck rising edge is detected on the synchronised signal.
  - spi_sck must be at most clk/4.
- Bit counter: counts 0-7 for the command byte, then 8-15 repeating for payload bytes.
  - Synchronised ss=1 clears the counter and the partial byte immediately, whatever state it is in.
  - A mid-byte deselect discards that byte.
- Commands, latched at bit 7:
  - 0x53 FILE_TX, payload bit0:
    - 1 = start: word/byte offset cleared, overflow cleared, base selected from index, downloading=1.
    - 0 = end: pending partial word flushed (see below), size=offset, state ENDING.
  - 0x54 FILE_TX_DAT: each completed byte goes to lane offset%BYTES of the assembly register and offset increments.
    - When the lane is BYTES-1, push {base+offset-(BYTES-1), word, all-ones be}.
  - 0x55 FILE_INDEX: index <= low 5 bits of payload. Ignored while downloading=1.
  - Any other command: payload ignored.
- Partial flush at end: if offset%BYTES != 0, push one entry.
  - be has only the received lanes set; unused lanes are 0 in data.
- FIFO:
  - Push and pop in the same cycle is allowed; count unchanged.
  - Push when full: the entry is dropped, overflow=1 (sticky until next start), and offset still advances.
- Write port state machine:
  - IDLE: FIFO not empty -> load head onto ram_addr/ram_din/ram_be, ram_wr_req=1, go to WAIT.
  - WAIT: outputs held stable until ram_wr_ack=1, then pop. Go to IDLE, or reload next entry the following cycle.
  - Minimum one idle cycle between requests.
  - ram_wr_ack while in IDLE is ignored.
- downloading state sequence: IDLE -> ACTIVE (start) -> ENDING (end) -> IDLE once the FIFO is empty and no request is outstanding.
  - A new start while in ENDING restarts offset but does not discard queued entries.
- Address arithmetic: modulo 2^AW; offset wrap is not flagged.
- Reset mid-transfer: everything returns to reset values next cycle. A pending ram_wr_req drops without waiting for ack.

Optional Feature:
Macro DATA_IO_CHECKSUM_EN.
- Defined: adds output checksum [15:0], the 16-bit modulo sum of all FILE_TX_DAT bytes.
  - Cleared on start and on reset.
  - Updated one cycle after each byte completes.
  - Valid from the cycle downloading falls.
  - Includes bytes dropped by overflow.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- BYTES=2, index=1, start, 4 data bytes 11 22 33 44, end -> writes A0000:2211 be=11 and A0002:4433 be=11; size=4; downloading falls after second ack.
- BYTES=4, index=0, 5 bytes 01..05 -> 80000:04030201 be=1111, then 80004:00000005 be=0001; size=5.
- FIFO_DEPTH=2, ram_wr_ack held low, 8 bytes at BYTES=2 -> overflow=1, exactly 2 entries retained; overflow clears on next start.
- Deassert spi_ss after 3 bits of a data byte, resume with new command 0x54 -> partial byte discarded, offset unchanged.
- Assert reset while ram_wr_req=1 and downloading=1 -> next cycle all outputs at reset values, no ack required.
- With DATA_IO_CHECKSUM_EN, bytes FF FF 02 -> checksum=0x0200 when downloading falls.
